axi4lite_regbridge: RTL and testbench

//  Parametrised AXI4-Lite slave to Bus2Reg master bridge; next generation of the single-beat regmap bridge.

---
 rtl/axi4lite_regbridge_if.sv | 52 +++++
 rtl/axi4lite_regbridge.sv | 226 ++++++++++++++++++++++
 tb/tb_axi4lite_regbridge.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_regbridge_if.sv
// Signal bundle between the SoC AXI4-Lite interconnect, the register bridge and the generated regmap.
// The slave modport is the bridge view; the master modport is the surrounding system (interconnect plus regmap).
interface axi4lite_regbridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_W-1:0]     WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    logic                  bus_req;
    logic                  bus_req_is_wr;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wr_data;
    logic [DATA_WIDTH-1:0] bus_wr_biten;
    logic                  bus_req_stall_wr;
    logic                  bus_req_stall_rd;
    logic                  bus_ready;
    logic [DATA_WIDTH-1:0] bus_rd_data;
    logic                  bus_rd_err;
    logic                  bus_wr_err;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        input  bus_req_stall_wr, bus_req_stall_rd, bus_ready, bus_rd_data, bus_rd_err, bus_wr_err
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        output bus_req_stall_wr, bus_req_stall_rd, bus_ready, bus_rd_data, bus_rd_err, bus_wr_err
    );
endinterface

// File: rtl/axi4lite_regbridge.sv
// AXI4-Lite slave to Bus2Reg master bridge: one-slot AW/W/AR capture, round-robin grant,
// address-window DECERR, regmap error propagation and a request timeout answered with SLVERR.
module axi4lite_regbridge #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LO        = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_HI        = ADDR_WIDTH'('hFFF),
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic ACLK,
    input  logic ARESETN,
    axi4lite_regbridge_if.slave bif
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB_W  = $clog2(STRB_W);
    localparam int TMR_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

    logic                  active_reg;
    logic                  aw_full_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic                  w_full_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_W-1:0]     w_strb_reg;
    logic                  ar_full_reg;
    logic [ADDR_WIDTH-1:0] ar_addr_reg;

    state_t                state_reg;
    logic                  last_wr_reg;
    logic                  cur_wr_reg;
    logic                  bus_req_reg;
    logic [ADDR_WIDTH-1:0] bus_addr_reg;
    logic [DATA_WIDTH-1:0] wr_data_reg;
    logic [DATA_WIDTH-1:0] biten_reg;
    logic [TMR_W-1:0]      timer_reg;
    logic                  rvalid_reg;
    logic                  bvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic [1:0]            bresp_reg;

    logic aw_hs, w_hs, ar_hs, r_done, b_done;
    logic aw_have, w_have, ar_have;
    logic [ADDR_WIDTH-1:0] aw_addr_cur, ar_addr_cur, sel_addr, sel_addr_aligned;
    logic [DATA_WIDTH-1:0] w_data_cur, biten_cur;
    logic [STRB_W-1:0]     w_strb_cur;
    logic wr_lo_ok, rd_lo_ok, wr_in_win, rd_in_win, sel_in_win;
    logic wr_elig, rd_elig, grant_wr, grant_any;

    assign bif.AWREADY = active_reg & ~aw_full_reg;
    assign bif.WREADY  = active_reg & ~w_full_reg;
    assign bif.ARREADY = active_reg & ~ar_full_reg;

    assign aw_hs  = bif.AWVALID & bif.AWREADY;
    assign w_hs   = bif.WVALID  & bif.WREADY;
    assign ar_hs  = bif.ARVALID & bif.ARREADY;
    assign r_done = rvalid_reg & bif.RREADY;
    assign b_done = bvalid_reg & bif.BREADY;

    // A channel accepted this cycle is visible to the grant logic at once, saving a cycle of latency.
    assign aw_have     = aw_full_reg | aw_hs;
    assign w_have      = w_full_reg  | w_hs;
    assign ar_have     = ar_full_reg | ar_hs;
    assign aw_addr_cur = aw_full_reg ? aw_addr_reg : bif.AWADDR;
    assign ar_addr_cur = ar_full_reg ? ar_addr_reg : bif.ARADDR;
    assign w_data_cur  = w_full_reg  ? w_data_reg  : bif.WDATA;
    assign w_strb_cur  = w_full_reg  ? w_strb_reg  : bif.WSTRB;

    generate
        if (ADDR_LO == '0) begin : g_lo_open
            assign wr_lo_ok = 1'b1;
            assign rd_lo_ok = 1'b1;
        end else begin : g_lo_cmp
            assign wr_lo_ok = (aw_addr_cur >= ADDR_LO);
            assign rd_lo_ok = (ar_addr_cur >= ADDR_LO);
        end
    endgenerate

    assign wr_in_win = wr_lo_ok & (aw_addr_cur <= ADDR_HI);
    assign rd_in_win = rd_lo_ok & (ar_addr_cur <= ADDR_HI);

    // Stalls only block transactions that would reach the regmap; decode errors answer regardless.
    assign wr_elig   = aw_have & w_have & (~wr_in_win | ~bif.bus_req_stall_wr);
    assign rd_elig   = ar_have & (~rd_in_win | ~bif.bus_req_stall_rd);
    assign grant_wr  = wr_elig & (~rd_elig | ~last_wr_reg);
    assign grant_any = wr_elig | rd_elig;

    assign sel_addr         = grant_wr ? aw_addr_cur : ar_addr_cur;
    assign sel_in_win       = grant_wr ? wr_in_win : rd_in_win;
    assign sel_addr_aligned = {sel_addr[ADDR_WIDTH-1:LSB_W], {LSB_W{1'b0}}};

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_biten
        assign biten_cur[8*gi +: 8] = {8{w_strb_cur[gi]}};
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            active_reg  <= 1'b0;
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            ar_full_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            ar_addr_reg <= '0;
        end else begin
            active_reg <= 1'b1;
            if (aw_hs) begin
                aw_full_reg <= 1'b1;
                aw_addr_reg <= bif.AWADDR;
            end else if (b_done) begin
                aw_full_reg <= 1'b0;
            end
            if (w_hs) begin
                w_full_reg <= 1'b1;
                w_data_reg <= bif.WDATA;
                w_strb_reg <= bif.WSTRB;
            end else if (b_done) begin
                w_full_reg <= 1'b0;
            end
            if (ar_hs) begin
                ar_full_reg <= 1'b1;
                ar_addr_reg <= bif.ARADDR;
            end else if (r_done) begin
                ar_full_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_reg    <= ST_IDLE;
            last_wr_reg  <= 1'b0;
            cur_wr_reg   <= 1'b0;
            bus_req_reg  <= 1'b0;
            bus_addr_reg <= '0;
            wr_data_reg  <= '0;
            biten_reg    <= '0;
            timer_reg    <= '0;
            rvalid_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
            bresp_reg    <= RESP_OKAY;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        last_wr_reg  <= grant_wr;
                        cur_wr_reg   <= grant_wr;
                        bus_addr_reg <= sel_addr_aligned;
                        wr_data_reg  <= grant_wr ? w_data_cur : '0;
                        biten_reg    <= grant_wr ? biten_cur : '0;
                        if (sel_in_win) begin
                            state_reg   <= ST_REQ;
                            bus_req_reg <= 1'b1;
                            timer_reg   <= '0;
                        end else begin
                            state_reg <= ST_RESP;
                            rdata_reg <= '0;
                            if (grant_wr) begin
                                bvalid_reg <= 1'b1;
                                bresp_reg  <= RESP_DECERR;
                            end else begin
                                rvalid_reg <= 1'b1;
                                rresp_reg  <= RESP_DECERR;
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (bif.bus_ready) begin
                        bus_req_reg <= 1'b0;
                        state_reg   <= ST_RESP;
                        if (cur_wr_reg) begin
                            bvalid_reg <= 1'b1;
                            bresp_reg  <= bif.bus_wr_err ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            rvalid_reg <= 1'b1;
                            rresp_reg  <= bif.bus_rd_err ? RESP_SLVERR : RESP_OKAY;
                            rdata_reg  <= bif.bus_rd_data;
                        end
                    end else if ((TIMEOUT_CYCLES != 0) && (timer_reg == TMR_LAST)) begin
                        bus_req_reg <= 1'b0;
                        state_reg   <= ST_RESP;
                        rdata_reg   <= '0;
                        if (cur_wr_reg) begin
                            bvalid_reg <= 1'b1;
                            bresp_reg  <= RESP_SLVERR;
                        end else begin
                            rvalid_reg <= 1'b1;
                            rresp_reg  <= RESP_SLVERR;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (r_done || b_done) begin
                        rvalid_reg <= 1'b0;
                        bvalid_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bif.bus_req       = bus_req_reg;
    assign bif.bus_req_is_wr = cur_wr_reg;
    assign bif.bus_addr      = bus_addr_reg;
    assign bif.bus_wr_data   = wr_data_reg;
    assign bif.bus_wr_biten  = biten_reg;
    assign bif.RVALID        = rvalid_reg;
    assign bif.RDATA         = rdata_reg;
    assign bif.RRESP         = rresp_reg;
    assign bif.BVALID        = bvalid_reg;
    assign bif.BRESP         = bresp_reg;
endmodule

// File: tb/tb_axi4lite_regbridge.sv
// Scenario bench for axi4lite_regbridge: expected responses are queued when stimulus is driven
// and popped when the bridge presents RVALID/BVALID.
module tb_axi4lite_regbridge;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct packed {
        logic        is_wr;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    axi4lite_regbridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bif ();

    axi4lite_regbridge #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ADDR_LO(32'h0), .ADDR_HI(32'hFFF), .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK(clk),
        .ARESETN(aresetn),
        .bif(bif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic is_wr, input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        e.is_wr = is_wr;
        e.resp  = resp;
        e.data  = data;
        sb.push_back(e);
    endtask

    task automatic wait_rsp(input logic is_wr, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((is_wr && bif.BVALID === 1'b1) || (!is_wr && bif.RVALID === 1'b1)) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bif.bus_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic init_inputs();
        bif.AWADDR = '0; bif.AWVALID = 1'b0;
        bif.WDATA = '0; bif.WSTRB = '0; bif.WVALID = 1'b0;
        bif.BREADY = 1'b1;
        bif.ARADDR = '0; bif.ARVALID = 1'b0;
        bif.RREADY = 1'b1;
        bif.bus_req_stall_wr = 1'b0; bif.bus_req_stall_rd = 1'b0;
        bif.bus_ready = 1'b0; bif.bus_rd_data = '0;
        bif.bus_rd_err = 1'b0; bif.bus_wr_err = 1'b0;
    endtask

    task automatic test_reset();
        init_inputs();
        aresetn = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bif.ARREADY, bif.AWREADY, bif.WREADY, bif.RVALID, bif.BVALID, bif.bus_req} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ar/aw/w_ready,rvalid,bvalid,bus_req=%b, required 000000",
                     {bif.ARREADY, bif.AWREADY, bif.WREADY, bif.RVALID, bif.BVALID, bif.bus_req});
        end
        aresetn = 1'b1;
        tick();
        vectors++;
        if ({bif.ARREADY, bif.AWREADY, bif.WREADY, bif.bus_req} !== 4'b1110) begin
            miscompares++;
            $display("FAIL reset_release: ar/aw/w_ready,bus_req=%b, required 1110",
                     {bif.ARREADY, bif.AWREADY, bif.WREADY, bif.bus_req});
        end
    endtask

    task automatic test_read_latency();
        exp_t e;
        bit   seen;
        sb.delete();
        push_exp(1'b0, 2'b00, 32'hDEADBEEF);
        bif.ARADDR = 32'h010;
        bif.ARVALID = 1'b1;
        tick();
        bif.ARVALID = 1'b0;
        vectors++;
        if (bif.bus_req !== 1'b1 || bif.bus_req_is_wr !== 1'b0 || bif.bus_addr !== 32'h010) begin
            miscompares++;
            $display("FAIL rd_req_cycle1: bus_req=%b is_wr=%b addr=%h, required 1 0 00000010",
                     bif.bus_req, bif.bus_req_is_wr, bif.bus_addr);
        end
        bif.bus_ready = 1'b1;
        bif.bus_rd_data = 32'hDEADBEEF;
        tick();
        bif.bus_ready = 1'b0;
        bif.bus_rd_data = '0;
        vectors++;
        if (bif.RVALID !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_rvalid_cycle2: rvalid=%b, required 1", bif.RVALID);
        end
        wait_rsp(1'b0, seen);
        vectors++;
        if (!seen || sb.size() == 0) begin
            miscompares++;
            $display("FAIL rd_rsp: rvalid=%b queued=%0d, required a read response", bif.RVALID, sb.size());
        end else begin
            e = sb.pop_front();
            if (e.is_wr !== 1'b0 || bif.RRESP !== e.resp || bif.RDATA !== e.data) begin
                miscompares++;
                $display("FAIL rd_data: rresp=%b rdata=%h, required rresp=%b rdata=%h",
                         bif.RRESP, bif.RDATA, e.resp, e.data);
            end
        end
        tick();
        vectors++;
        if (bif.RVALID !== 1'b0 || bif.ARREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_release: rvalid=%b arready=%b, required 0 1", bif.RVALID, bif.ARREADY);
        end
    endtask

    task automatic test_w_before_aw();
        exp_t e;
        bit   seen;
        int   early_req = 0;
        sb.delete();
        push_exp(1'b1, 2'b00, 32'h0);
        bif.WDATA = 32'h12345678;
        bif.WSTRB = 4'b0101;
        bif.WVALID = 1'b1;
        tick();
        bif.WVALID = 1'b0;
        vectors++;
        if (bif.WREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL w_slot_full: wready=%b, required 0", bif.WREADY);
        end
        for (int i = 0; i < 2; i++) begin
            if (bif.bus_req !== 1'b0) early_req++;
            tick();
        end
        bif.AWADDR = 32'h004;
        bif.AWVALID = 1'b1;
        tick();
        bif.AWVALID = 1'b0;
        vectors++;
        if (early_req != 0 || bif.bus_req !== 1'b1 || bif.bus_req_is_wr !== 1'b1 || bif.bus_addr !== 32'h004 ||
            bif.bus_wr_data !== 32'h12345678 || bif.bus_wr_biten !== 32'h00FF00FF) begin
            miscompares++;
            $display("FAIL wr_req: early=%0d req=%b is_wr=%b addr=%h data=%h biten=%h, required 0 1 1 00000004 12345678 00ff00ff",
                     early_req, bif.bus_req, bif.bus_req_is_wr, bif.bus_addr, bif.bus_wr_data, bif.bus_wr_biten);
        end
        bif.bus_ready = 1'b1;
        tick();
        bif.bus_ready = 1'b0;
        vectors++;
        if (bif.bus_req !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_single_req: bus_req=%b after bus_ready, required 0", bif.bus_req);
        end
        wait_rsp(1'b1, seen);
        vectors++;
        if (!seen || sb.size() == 0) begin
            miscompares++;
            $display("FAIL wr_rsp: bvalid=%b queued=%0d, required a write response", bif.BVALID, sb.size());
        end else begin
            e = sb.pop_front();
            if (e.is_wr !== 1'b1 || bif.BRESP !== e.resp) begin
                miscompares++;
                $display("FAIL wr_bresp: bresp=%b, required %b", bif.BRESP, e.resp);
            end
        end
        tick();
        vectors++;
        if ({bif.AWREADY, bif.WREADY, bif.BVALID} !== 3'b110) begin
            miscompares++;
            $display("FAIL wr_release: awready,wready,bvalid=%b, required 110", {bif.AWREADY, bif.WREADY, bif.BVALID});
        end
    endtask

    task automatic test_arbitration();
        exp_t e;
        bit   seen;
        sb.delete();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        push_exp(1'b1, 2'b00, 32'h0);
        push_exp(1'b0, 2'b00, 32'h0BADF00D);
        bif.ARADDR = 32'h008; bif.ARVALID = 1'b1;
        bif.AWADDR = 32'h00C; bif.AWVALID = 1'b1;
        bif.WDATA = 32'hA5A5A5A5; bif.WSTRB = 4'hF; bif.WVALID = 1'b1;
        tick();
        bif.ARVALID = 1'b0; bif.AWVALID = 1'b0; bif.WVALID = 1'b0;
        vectors++;
        if (bif.bus_req !== 1'b1 || bif.bus_req_is_wr !== 1'b1 || bif.bus_addr !== 32'h00C) begin
            miscompares++;
            $display("FAIL arb_first_write: req=%b is_wr=%b addr=%h, required 1 1 0000000c",
                     bif.bus_req, bif.bus_req_is_wr, bif.bus_addr);
        end
        bif.bus_ready = 1'b1;
        tick();
        bif.bus_ready = 1'b0;
        wait_rsp(1'b1, seen);
        vectors++;
        if (!seen || sb.size() == 0) begin
            miscompares++;
            $display("FAIL arb_wr_rsp: bvalid=%b queued=%0d, required write response first", bif.BVALID, sb.size());
        end else begin
            e = sb.pop_front();
            if (e.is_wr !== 1'b1 || bif.BRESP !== e.resp || bif.RVALID !== 1'b0) begin
                miscompares++;
                $display("FAIL arb_wr_bresp: bresp=%b rvalid=%b, required %b 0", bif.BRESP, bif.RVALID, e.resp);
            end
        end
        wait_req(seen);
        vectors++;
        if (!seen || bif.bus_req_is_wr !== 1'b0 || bif.bus_addr !== 32'h008) begin
            miscompares++;
            $display("FAIL arb_second_read: seen=%b is_wr=%b addr=%h, required 1 0 00000008",
                     seen, bif.bus_req_is_wr, bif.bus_addr);
        end
        bif.bus_ready = 1'b1;
        bif.bus_rd_data = 32'h0BADF00D;
        tick();
        bif.bus_ready = 1'b0;
        bif.bus_rd_data = '0;
        wait_rsp(1'b0, seen);
        vectors++;
        if (!seen || sb.size() == 0) begin
            miscompares++;
            $display("FAIL arb_rd_rsp: rvalid=%b queued=%0d, required read response", bif.RVALID, sb.size());
        end else begin
            e = sb.pop_front();
            if (e.is_wr !== 1'b0 || bif.RRESP !== e.resp || bif.RDATA !== e.data) begin
                miscompares++;
                $display("FAIL arb_rd_data: rresp=%b rdata=%h, required %b %h", bif.RRESP, bif.RDATA, e.resp, e.data);
            end
        end
        tick();
    endtask

    task automatic test_stall_and_reset();
        bit seen;
        int stalled_req = 0;
        sb.delete();
        bif.bus_req_stall_rd = 1'b1;
        bif.ARADDR = 32'h030;
        bif.ARVALID = 1'b1;
        tick();
        bif.ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bif.bus_req !== 1'b0 || bif.RVALID !== 1'b0) stalled_req++;
            tick();
        end
        vectors++;
        if (stalled_req != 0) begin
            miscompares++;
            $display("FAIL stall_rd: %0d cycles with bus_req/rvalid during stall, required 0", stalled_req);
        end
        bif.bus_req_stall_rd = 1'b0;
        wait_req(seen);
        vectors++;
        if (!seen || bif.bus_addr !== 32'h030) begin
            miscompares++;
            $display("FAIL stall_release: seen=%b addr=%h, required 1 00000030", seen, bif.bus_addr);
        end
        aresetn = 1'b0;
        tick();
        vectors++;
        if ({bif.ARREADY, bif.AWREADY, bif.WREADY, bif.RVALID, bif.BVALID, bif.bus_req} !== 6'b0 ||
            bif.RDATA !== 32'h0 || bif.RRESP !== 2'b00 || bif.BRESP !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_in_req: flags=%b rdata=%h rresp=%b bresp=%b, required 000000 00000000 00 00",
                     {bif.ARREADY, bif.AWREADY, bif.WREADY, bif.RVALID, bif.BVALID, bif.bus_req},
                     bif.RDATA, bif.RRESP, bif.BRESP);
        end
        aresetn = 1'b1;
        tick();
        vectors++;
        if ({bif.ARREADY, bif.AWREADY, bif.WREADY} !== 3'b111) begin
            miscompares++;
            $display("FAIL ready_after_reset: ar/aw/w_ready=%b, required 111", {bif.ARREADY, bif.AWREADY, bif.WREADY});
        end
        tick();
        tick();
        vectors++;
        if (bif.RVALID !== 1'b0 || bif.bus_req !== 1'b0) begin
            miscompares++;
            $display("FAIL abandoned_req: rvalid=%b bus_req=%b, required 0 0", bif.RVALID, bif.bus_req);
        end
    endtask

    task automatic test_decerr_slverr();
        exp_t        e;
        bit          seen;
        int          held_bad = 0;
        logic [31:0] addrs [2];
        sb.delete();
        bif.RREADY = 1'b0;
        push_exp(1'b0, 2'b11, 32'h0);
        bif.ARADDR = 32'h2000;
        bif.ARVALID = 1'b1;
        tick();
        bif.ARVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bif.bus_req !== 1'b0 || bif.RVALID !== 1'b1) held_bad++;
            if (i < 2) tick();
        end
        vectors++;
        if (held_bad != 0) begin
            miscompares++;
            $display("FAIL decerr_hold: %0d cycles with bus_req=1 or rvalid=0, required 0", held_bad);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL decerr_rsp: queued=0, required a queued read");
        end else begin
            e = sb.pop_front();
            if (bif.RRESP !== e.resp || bif.RDATA !== e.data) begin
                miscompares++;
                $display("FAIL decerr_data: rresp=%b rdata=%h, required %b %h", bif.RRESP, bif.RDATA, e.resp, e.data);
            end
        end
        bif.RREADY = 1'b1;
        tick();

        addrs = '{32'h00000FFC, 32'h00001000};
        for (int i = 0; i < 2; i++) begin
            if (i == 0) push_exp(1'b0, 2'b00, 32'h5A5A0FFC);
            else        push_exp(1'b0, 2'b11, 32'h0);
            bif.ARADDR = addrs[i];
            bif.ARVALID = 1'b1;
            tick();
            bif.ARVALID = 1'b0;
            vectors++;
            if (bif.bus_req !== (i == 0)) begin
                miscompares++;
                $display("FAIL window_edge_%0d: addr=%h bus_req=%b, required %b", i, addrs[i], bif.bus_req, (i == 0));
            end
            if (bif.bus_req === 1'b1) begin
                bif.bus_ready = 1'b1;
                bif.bus_rd_data = 32'h5A5A0FFC;
                tick();
                bif.bus_ready = 1'b0;
                bif.bus_rd_data = '0;
            end
            wait_rsp(1'b0, seen);
            vectors++;
            if (!seen || sb.size() == 0) begin
                miscompares++;
                $display("FAIL window_rsp_%0d: rvalid=%b queued=%0d, required a response", i, bif.RVALID, sb.size());
            end else begin
                e = sb.pop_front();
                if (bif.RRESP !== e.resp || bif.RDATA !== e.data) begin
                    miscompares++;
                    $display("FAIL window_data_%0d: rresp=%b rdata=%h, required %b %h", i, bif.RRESP, bif.RDATA, e.resp, e.data);
                end
            end
            tick();
        end

        push_exp(1'b1, 2'b10, 32'h0);
        bif.AWADDR = 32'h040; bif.AWVALID = 1'b1;
        bif.WDATA = 32'hFEEDFACE; bif.WSTRB = 4'hF; bif.WVALID = 1'b1;
        tick();
        bif.AWVALID = 1'b0; bif.WVALID = 1'b0;
        bif.bus_ready = 1'b1;
        bif.bus_wr_err = 1'b1;
        tick();
        bif.bus_ready = 1'b0;
        bif.bus_wr_err = 1'b0;
        wait_rsp(1'b1, seen);
        vectors++;
        if (!seen || sb.size() == 0) begin
            miscompares++;
            $display("FAIL wr_err_rsp: bvalid=%b queued=%0d, required a write response", bif.BVALID, sb.size());
        end else begin
            e = sb.pop_front();
            if (bif.BRESP !== e.resp) begin
                miscompares++;
                $display("FAIL wr_err_bresp: bresp=%b, required %b", bif.BRESP, e.resp);
            end
        end
        tick();
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   seen;
        int   req_cycles = 0;
        sb.delete();
        push_exp(1'b0, 2'b10, 32'h0);
        bif.bus_rd_data = 32'hFFFFFFFF;
        bif.ARADDR = 32'h020;
        bif.ARVALID = 1'b1;
        tick();
        bif.ARVALID = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bif.bus_req !== 1'b1) break;
            req_cycles++;
            tick();
        end
        vectors++;
        if (req_cycles != 8) begin
            miscompares++;
            $display("FAIL timeout_len: bus_req high %0d cycles, required 8", req_cycles);
        end
        wait_rsp(1'b0, seen);
        vectors++;
        if (!seen || sb.size() == 0) begin
            miscompares++;
            $display("FAIL timeout_rsp: rvalid=%b queued=%0d, required a read response", bif.RVALID, sb.size());
        end else begin
            e = sb.pop_front();
            if (bif.RRESP !== e.resp || bif.RDATA !== e.data) begin
                miscompares++;
                $display("FAIL timeout_data: rresp=%b rdata=%h, required %b %h", bif.RRESP, bif.RDATA, e.resp, e.data);
            end
        end
        bif.bus_rd_data = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_w_before_aw();
        test_arbitration();
        test_stall_and_reset();
        test_decerr_slverr();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
